mc_phase_ctrl: RTL and testbench

Parametrised phase sequencer for the multicycle RV32I core. It generates the per-phase enables that step the fetch, decode, execute, memory and writeback stages. Compared with the fixed-latency controller, it adds:
- AHB wait-state handling via `bus_ready`/`bus_err`, with a wait timeout;
- a configurable execute length, plus a longer one for multi-cycle ops;
- illegal-opcode and bus-fault trapping;
- a retired-instruction counter.

It sits between the decode stage (opcode source) and the stage datapaths / AHB master.

---
 rtl/mc_phase_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mc_phase_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_phase_ctrl.sv
// mc_phase_ctrl: multicycle RV32I phase sequencer.
// Steps fetch/decode/exec/mem/wb with AHB wait, timeout and trap handling.
module mc_phase_ctrl #(
  parameter int EX_CYCLES    = 1,
  parameter int MD_CYCLES    = 4,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        md_op,
  input  logic        bus_ready,
  input  logic        bus_err,
  input  logic        trap_ack,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        bus_req,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  localparam int WW    = $clog2(WAIT_TIMEOUT + 1);
  localparam int EXMAX = (EX_CYCLES > MD_CYCLES) ? EX_CYCLES : MD_CYCLES;
  localparam int CW    = $clog2(EXMAX + 1);

  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);
  localparam logic [CW-1:0] EX_LAST   = CW'(EX_CYCLES - 1);
  localparam logic [CW-1:0] MD_LAST   = CW'(MD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } st_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_OP,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_ILL
  } cls_e;

  st_e             state_q, state_d;
  cls_e            cls_q, cls_d, cls_dec;
  logic            md_q, md_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CW-1:0]   exc_q, exc_d;
  logic [1:0]      cause_q, cause_d;
  logic [31:0]     ret_q, ret_d;
  logic [CW-1:0]   ex_last;
  logic            retire;

  // Classify the incoming opcode; only consumed in DECODE.
  always_comb begin
    cls_dec = C_ILL;
    case (opcode)
      7'b0110111,
      7'b0010111,
      7'b1101111,
      7'b1100111,
      7'b0010011: cls_dec = C_ALU;
      7'b0110011: cls_dec = C_OP;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      default:    cls_dec = C_ILL;
    endcase
  end

  assign ex_last = md_q ? MD_LAST : EX_LAST;

  // Next-state, phase enables and trap cause.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    md_d    = md_q;
    wait_d  = wait_q;
    exc_d   = exc_q;
    cause_d = cause_q;
    if_en   = 1'b0;
    id_en   = 1'b0;
    ex_en   = 1'b0;
    mem_en  = 1'b0;
    wb_en   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_MEM: begin
        if (bus_err) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else if (bus_ready) begin
          wait_d = '0;
          if (state_q == S_FETCH) begin
            if_en   = 1'b1;
            state_d = S_DECODE;
          end else begin
            mem_en  = 1'b1;
            state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        id_en = 1'b1;
        cls_d = cls_dec;
        md_d  = (cls_dec == C_OP) && md_op;
        exc_d = '0;
        if (cls_dec == C_ILL) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exc_q == ex_last) begin
          ex_en = 1'b1;
          unique case (1'b1)
            (cls_q == C_LOAD),
            (cls_q == C_STORE): state_d = S_MEM;
            (cls_q == C_BRANCH): state_d = S_FETCH;
            default: state_d = S_WB;
          endcase
        end else begin
          exc_d = exc_q + 1'b1;
        end
      end
      S_WB: begin
        wb_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        if (trap_ack) begin
          state_d = S_FETCH;
          cause_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  assign retire = wb_en
                | (mem_en && cls_q == C_STORE)
                | (ex_en && cls_q == C_BRANCH);

  // Retired-instruction counter, wraps naturally.
  always_comb begin
    ret_d = ret_q;
    if (retire) ret_d = ret_q + 32'd1;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cls_q   <= C_ALU;
      md_q    <= 1'b0;
      wait_q  <= '0;
      exc_q   <= '0;
      cause_q <= 2'b00;
      ret_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      md_q    <= md_d;
      wait_q  <= wait_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
    end
  end

  assign bus_req    = (state_q == S_FETCH) || (state_q == S_MEM);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state      = state_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_mc_phase_ctrl.sv
// tb_mc_phase_ctrl: randomized bench for mc_phase_ctrl.
// Expected phase timelines are built per instruction from wait/fault plans.
module tb_mc_phase_ctrl;

  localparam int EXC = 1;
  localparam int MDC = 4;
  localparam int TO  = 16;

  localparam logic [6:0] OP_OP = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic        md_op = 1'b0;
  logic        bus_ready = 1'b0;
  logic        bus_err = 1'b0;
  logic        trap_ack = 1'b0;
  logic        if_en, id_en, ex_en, mem_en, wb_en;
  logic        bus_req, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [31:0] retired;

  mc_phase_ctrl #(
    .EX_CYCLES(EXC),
    .MD_CYCLES(MDC),
    .WAIT_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .md_op(md_op),
    .bus_ready(bus_ready),
    .bus_err(bus_err),
    .trap_ack(trap_ack),
    .if_en(if_en),
    .id_en(id_en),
    .ex_en(ex_en),
    .mem_en(mem_en),
    .wb_en(wb_en),
    .bus_req(bus_req),
    .trap(trap),
    .trap_cause(trap_cause),
    .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_ret = 32'd0;
  logic [2:0]  q_st[$];
  logic [4:0]  q_en[$];
  int          q_bus[$];
  int          dec_k;
  logic [2:0]  end_st;
  logic [1:0]  end_cause;
  logic [6:0]  legal_ops[9] = '{7'b0110111, 7'b0010111, 7'b1101111,
                                7'b1100111, 7'b1100011, 7'b0000011,
                                7'b0100011, 7'b0010011, 7'b0110011};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    bit r = 0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) r = 1;
    return r;
  endfunction

  function automatic logic [4:0] ens();
    return {if_en, id_en, ex_en, mem_en, wb_en};
  endfunction

  // bus code: 0 wait, 1 complete, 2 error, 3 don't care
  function automatic void push(input logic [2:0] s, input logic [4:0] e,
                               input int b);
    q_st.push_back(s);
    q_en.push_back(e);
    q_bus.push_back(b);
  endfunction

  task automatic bus_phase(input logic [2:0] s, input logic [4:0] e,
                           input int w, input bit err, output bit ok);
    ok = 0;
    if (w >= TO) begin
      repeat (TO) push(s, 5'b0, 0);
      end_st = 3'd6;
      end_cause = 2'b11;
      return;
    end
    repeat (w) push(s, 5'b0, 0);
    if (err) begin
      push(s, 5'b0, 2);
      end_st = 3'd6;
      end_cause = 2'b10;
      return;
    end
    push(s, e, 1);
    ok = 1;
  endtask

  task automatic plan(input logic [6:0] op, input bit md, input int wf,
                      input bit ferr, input int wm, input bit merr);
    bit ok;
    int n;
    q_st.delete();
    q_en.delete();
    q_bus.delete();
    dec_k = -1;
    end_st = 3'd1;
    end_cause = 2'b00;
    bus_phase(3'd1, 5'b10000, wf, ferr, ok);
    if (!ok) return;
    push(3'd2, 5'b01000, 3);
    dec_k = q_st.size() - 1;
    if (!legal(op)) begin
      end_st = 3'd6;
      end_cause = 2'b01;
      return;
    end
    n = (op == OP_OP && md) ? MDC : EXC;
    repeat (n - 1) push(3'd3, 5'b0, 3);
    push(3'd3, 5'b00100, 3);
    if (op == OP_BR) begin
      exp_ret++;
      return;
    end
    if (op == OP_LD || op == OP_ST) begin
      bus_phase(3'd4, 5'b00010, wm, merr, ok);
      if (!ok) return;
      if (op == OP_ST) begin
        exp_ret++;
        return;
      end
    end
    push(3'd5, 5'b00001, 3);
    exp_ret++;
  endtask

  task automatic drive(input int k, input logic [6:0] op, input bit md);
    bus_ready = 1'($urandom);
    bus_err   = 1'($urandom);
    trap_ack  = 1'($urandom);
    opcode    = 7'($urandom);
    md_op     = 1'($urandom);
    case (q_bus[k])
      0: begin bus_ready = 1'b0; bus_err = 1'b0; end
      1: begin bus_ready = 1'b1; bus_err = 1'b0; end
      2: bus_err = 1'b1;
      default: ;
    endcase
    if (k == dec_k) begin
      opcode = op;
      md_op  = md;
    end
  endtask

  task automatic run(input logic [6:0] op, input bit md, input int wf,
                     input bit ferr, input int wm, input bit merr,
                     input int abort_k);
    int h;
    plan(op, md, wf, ferr, wm, merr);
    for (int k = 0; k < q_st.size(); k++) begin
      if (k == abort_k) begin
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_en", 32'(ens()), 32'd0);
        chk("abort_req", 32'(bus_req), 32'd0);
        chk("abort_trap", 32'({trap, trap_cause}), 32'd0);
        chk("abort_ret", retired, 32'd0);
        exp_ret = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("deassert_en", 32'(ens()), 32'd0);
        chk("deassert_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        chk("after_abort", 32'(state), 32'd1);
        return;
      end
      drive(k, op, md);
      @(negedge clk);
      chk("state", 32'(state), 32'(q_st[k]));
      chk("enables", 32'(ens()), 32'(q_en[k]));
      chk("bus_req", 32'(bus_req), 32'(q_st[k] == 3'd1 || q_st[k] == 3'd4));
      chk("trap_low", 32'(trap), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("end_state", 32'(state), 32'(end_st));
    chk("end_cause", 32'(trap_cause), 32'(end_cause));
    chk("retired", retired, exp_ret);
    if (end_st == 3'd6) begin
      h = $urandom_range(0, 3);
      repeat (h) begin
        drive(0, op, md);
        trap_ack = 1'b0;
        @(negedge clk);
        chk("trap_hold", 32'(state), 32'd6);
        chk("trap_out", 32'(trap), 32'd1);
        chk("trap_en", 32'({ens(), bus_req}), 32'd0);
        chk("trap_cause_hold", 32'(trap_cause), 32'(end_cause));
        @(posedge clk);
        #1;
      end
      drive(0, op, md);
      trap_ack = 1'b1;
      @(negedge clk);
      chk("trap_ack_en", 32'({ens(), bus_req}), 32'd0);
      @(posedge clk);
      #1;
      trap_ack = 1'b0;
      chk("trap_exit", 32'(state), 32'd1);
      chk("trap_clear", 32'(trap_cause), 32'd0);
      chk("trap_ret", retired, exp_ret);
    end
  endtask

  initial begin
    logic [6:0] op;
    int r;
    int wf;
    int wm;
    reset = 1'b0;
    bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_en", 32'({ens(), bus_req, trap}), 32'd0);
    chk("reset_cause", 32'(trap_cause), 32'd0);
    chk("reset_ret", retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle_req", 32'(bus_req), 32'd0);
    @(posedge clk);
    #1;
    chk("first_fetch", 32'(state), 32'd1);

    run(OP_OP, 1'b0, 0, 1'b0, 0, 1'b0, -1);
    run(OP_LD, 1'b0, 2, 1'b0, 3, 1'b0, -1);
    run(OP_OP, 1'b1, 0, 1'b0, 0, 1'b0, -1);
    run(OP_OP, 1'b0, 1, 1'b0, 0, 1'b0, -1);
    run(OP_OP, 1'b0, TO, 1'b0, 0, 1'b0, -1);
    run(OP_ST, 1'b0, 0, 1'b0, 1, 1'b1, -1);
    run(7'b0000000, 1'b0, 0, 1'b0, 0, 1'b0, -1);
    run(OP_BR, 1'b1, 0, 1'b0, 0, 1'b0, -1);
    run(OP_ST, 1'b0, 0, 1'b0, 0, 1'b0, -1);
    run(OP_LD, 1'b0, 0, 1'b0, TO, 1'b0, -1);
    run(OP_ST, 1'b0, 0, 1'b1, 0, 1'b0, -1);

    force dut.ret_q = 32'hFFFF_FFFF;
    #1;
    release dut.ret_q;
    exp_ret = 32'hFFFF_FFFF;
    run(OP_ST, 1'b0, 0, 1'b0, 0, 1'b0, -1);
    chk("wrap", retired, 32'd0);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 19);
      if (r < 9) begin
        op = legal_ops[r];
      end else if (r < 15) begin
        op = (r < 12) ? OP_OP : ((r < 14) ? OP_LD : OP_ST);
      end else begin
        op = 7'($urandom);
        while (legal(op)) op = 7'($urandom);
      end
      wf = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 3);
      wm = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 3);
      run(op, 1'($urandom), wf, $urandom_range(0, 19) == 0,
          wm, $urandom_range(0, 19) == 0, -1);
    end

    run(OP_OP, 1'b1, 0, 1'b0, 0, 1'b0, 3);
    run(OP_OP, 1'b0, 0, 1'b0, 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
